keyboard_autotype: RTL and testbench

- Sits between the MiSTer ps2_key vector and the Lynx keyboard matrix block. Drives that block's 11-bit event input.
- Normally passes real key events through unchanged.
- On start, it plays a stored scancode sequence as synthetic press/release events, e.g. typing a cassette LOAD command.
- Arbitrates the single event channel between real typing and injection, buffering one real event while it injects.

---
 rtl/lynx_kbd_pkg.sv | 53 +++++
 rtl/autotype_rom.sv | 35 +++
 rtl/keyboard_autotype.sv | 242 ++++++++++++++++++++++++
 tb/tb_keyboard_autotype.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_kbd_pkg.sv
// Shared types and constants for the Lynx keyboard autotype path:
// FSM state encoding, special scancodes, event field positions, default typed sequence.
package lynx_kbd_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    SHIFT_DN = 4'd2,
    KEY_DN   = 4'd3,
    HOLD     = 4'd4,
    KEY_UP   = 4'd5,
    SHIFT_UP = 4'd6,
    GAP      = 4'd7,
    DONE     = 4'd8
  } state_e;

  localparam logic [7:0] SC_SHIFT = 8'h12;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_END   = 8'h00;

  localparam int EV_TOGGLE   = 10;
  localparam int EV_PRESSED  = 9;
  localparam int EV_EXT      = 8;
  localparam int EV_CODE_MSB = 7;

  // Injected events are never extended.
  function automatic logic [9:0] make_event(input logic pressed, input logic [7:0] code);
    logic [9:0] ev;
    ev = 10'h000;
    ev[EV_PRESSED] = pressed;
    ev[EV_EXT] = 1'b0;
    ev[EV_CODE_MSB:0] = code;
    return ev;
  endfunction

  // LOAD "" followed by return; the quote is shift + the apostrophe key.
  function automatic logic [8:0] load_seq_word(input logic [7:0] idx);
    logic [8:0] w;
    case (idx)
      8'd0:    w = 9'h04B;
      8'd1:    w = 9'h044;
      8'd2:    w = 9'h01C;
      8'd3:    w = 9'h023;
      8'd4:    w = 9'h029;
      8'd5:    w = 9'h152;
      8'd6:    w = 9'h152;
      8'd7:    w = 9'h05A;
      default: w = 9'h000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/autotype_rom.sv
// Registered sequence table (one-cycle read latency) holding the default autotype sequence.
module autotype_rom
  import lynx_kbd_pkg::*;
#(
  parameter int SEQ_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SEQ_AW-1:0] addr,
  output logic [8:0]        data
);

  logic [7:0] idx_s;
  logic [8:0] data_q;
  logic [8:0] data_d;

  // Zero-extend the address into the table index and look up the word.
  always_comb begin
    idx_s = 8'h00;
    idx_s[SEQ_AW-1:0] = addr;
    data_d = load_seq_word(idx_s);
  end

  // Read register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= 9'h000;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/keyboard_autotype.sv
// Arbitrates the keyboard event channel between real PS/2 events and a stored
// scancode sequence replayed as synthetic press/release events.
module keyboard_autotype
  import lynx_kbd_pkg::*;
#(
  parameter logic [15:0] HOLD_TICKS = 16'd40000,
  parameter logic [15:0] GAP_TICKS  = 16'd40000,
  parameter int          SEQ_AW     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic [10:0]       ps2_in,
  input  logic              start,
  output logic [SEQ_AW-1:0] seq_addr,
  input  logic [8:0]        seq_data,
  output logic [10:0]       ps2_out,
  output logic              busy,
  output logic              overflow
);

  state_e            state_q, state_d;
  logic [10:0]       ps2_out_q, ps2_out_d;
  logic              busy_q, busy_d;
  logic [SEQ_AW-1:0] seq_addr_q, seq_addr_d;
  logic              overflow_q, overflow_d;
  logic [9:0]        pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              abort_q, abort_d;
  logic [15:0]       timer_q, timer_d;
  logic [7:0]        code_q, code_d;
  logic              shift_q, shift_d;
  logic              fetch_wait_q, fetch_wait_d;
  logic              in_tog_q, in_tog_d;

  logic              in_evt_s;
  logic              esc_s;
  logic              emit_s;
  logic [9:0]        emit_val_s;

  assign in_evt_s = ps2_in[EV_TOGGLE] ^ in_tog_q;
  assign esc_s    = in_evt_s && ps2_in[EV_PRESSED] && (ps2_in[EV_CODE_MSB:0] == SC_ESC);

  // Next-state logic: real-event buffering plus the injection sequencer.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    seq_addr_d   = seq_addr_q;
    overflow_d   = overflow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    abort_d      = abort_q;
    timer_d      = timer_q;
    code_d       = code_q;
    shift_d      = shift_q;
    fetch_wait_d = fetch_wait_q;
    in_tog_d     = ps2_in[EV_TOGGLE];
    emit_s       = 1'b0;
    emit_val_s   = 10'h000;

    // Real events: pass through when idle (buffered one first), otherwise hold in pending.
    if (state_q == IDLE) begin
      if (pend_valid_q) begin
        emit_s     = 1'b1;
        emit_val_s = pend_q;
        if (in_evt_s) begin
          pend_d = ps2_in[9:0];
        end else begin
          pend_valid_d = 1'b0;
        end
      end else if (in_evt_s) begin
        emit_s     = 1'b1;
        emit_val_s = ps2_in[9:0];
      end else begin
        emit_s = 1'b0;
      end
    end else if (in_evt_s) begin
      pend_d       = ps2_in[9:0];
      pend_valid_d = 1'b1;
      overflow_d   = overflow_q | pend_valid_q;
      abort_d      = abort_q | esc_s;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seq_addr_d   = '0;
          busy_d       = 1'b1;
          overflow_d   = 1'b0;
          abort_d      = 1'b0;
          fetch_wait_d = 1'b0;
          state_d      = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      // The table answers one cycle after the address, so FETCH spends a wait cycle first.
      FETCH: begin
        if (abort_q) begin
          state_d = DONE;
        end else if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          fetch_wait_d = 1'b0;
          code_d       = seq_data[7:0];
          shift_d      = seq_data[8];
          if (seq_data[7:0] == SC_END) begin
            state_d = DONE;
          end else if (seq_data[8]) begin
            state_d = SHIFT_DN;
          end else begin
            state_d = KEY_DN;
          end
        end
      end
      SHIFT_DN: begin
        if (abort_q) begin
          state_d = DONE;
        end else begin
          emit_s     = 1'b1;
          emit_val_s = make_event(1'b1, SC_SHIFT);
          state_d    = KEY_DN;
        end
      end
      KEY_DN: begin
        if (abort_q) begin
          state_d = KEY_UP;
        end else begin
          emit_s     = 1'b1;
          emit_val_s = make_event(1'b1, code_q);
          timer_d    = HOLD_TICKS;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (abort_q || (timer_q == 16'd0)) begin
          state_d = KEY_UP;
        end else if (ce) begin
          timer_d = timer_q - 16'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      // Releases are always emitted, even on abort, so no key stays held.
      KEY_UP: begin
        emit_s     = 1'b1;
        emit_val_s = make_event(1'b0, code_q);
        if (shift_q) begin
          state_d = SHIFT_UP;
        end else if (abort_q) begin
          state_d = DONE;
        end else begin
          timer_d = GAP_TICKS;
          state_d = GAP;
        end
      end
      SHIFT_UP: begin
        emit_s     = 1'b1;
        emit_val_s = make_event(1'b0, SC_SHIFT);
        if (abort_q) begin
          state_d = DONE;
        end else begin
          timer_d = GAP_TICKS;
          state_d = GAP;
        end
      end
      GAP: begin
        if (abort_q) begin
          state_d = DONE;
        end else if (timer_q == 16'd0) begin
          if (seq_addr_q == {SEQ_AW{1'b1}}) begin
            state_d = DONE;
          end else begin
            seq_addr_d   = seq_addr_q + 1'b1;
            fetch_wait_d = 1'b0;
            state_d      = FETCH;
          end
        end else if (ce) begin
          timer_d = timer_q - 16'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (emit_s) begin
      ps2_out_d = {~ps2_out_q[EV_TOGGLE], emit_val_s};
    end else begin
      ps2_out_d = ps2_out_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ps2_out_q    <= 11'h000;
      busy_q       <= 1'b0;
      seq_addr_q   <= '0;
      overflow_q   <= 1'b0;
      pend_q       <= 10'h000;
      pend_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      timer_q      <= 16'd0;
      code_q       <= 8'h00;
      shift_q      <= 1'b0;
      fetch_wait_q <= 1'b0;
      in_tog_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ps2_out_q    <= ps2_out_d;
      busy_q       <= busy_d;
      seq_addr_q   <= seq_addr_d;
      overflow_q   <= overflow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      abort_q      <= abort_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      fetch_wait_q <= fetch_wait_d;
      in_tog_q     <= in_tog_d;
    end
  end

  assign ps2_out  = ps2_out_q;
  assign busy     = busy_q;
  assign seq_addr = seq_addr_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keyboard_autotype.sv
// Directed bench for keyboard_autotype: passthrough, sequence injection, pending
// overflow, escape abort, full-table run, ce freeze and async reset.
module tb_keyboard_autotype;

  localparam logic [15:0] HOLD = 16'd3;
  localparam logic [15:0] GAPT = 16'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [10:0] ps2_in = 11'h000;
  logic [3:0]  seq_addr;
  logic [8:0]  seq_data = 9'h000;
  logic [10:0] ps2_out;
  logic        busy;
  logic        overflow;

  logic [8:0]  rom_mem [16];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [9:0]  ev_q [$];
  int          ev_cyc [$];
  logic        last_tog = 1'b0;

  keyboard_autotype #(.HOLD_TICKS(HOLD), .GAP_TICKS(GAPT), .SEQ_AW(4)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2_in(ps2_in), .start(start),
    .seq_addr(seq_addr), .seq_data(seq_data), .ps2_out(ps2_out),
    .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Sequence table model with one-cycle read latency.
  always @(posedge clock) seq_data <= rom_mem[seq_addr];

  // Emit monitor: every toggle of ps2_out[10] is one event.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (ps2_out[10] !== last_tog) begin
      ev_q.push_back(ps2_out[9:0]);
      ev_cyc.push_back(cyc);
      last_tog = ps2_out[10];
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom_mem[i] = 9'h000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_key(input logic p, input logic [7:0] c);
    ps2_in = {~ps2_in[10], p, 1'b0, c};
    tick();
  endtask

  function automatic logic [9:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 10'h3FF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < ev_cyc.size()) return ev_cyc[i];
    return -1000;
  endfunction

  task automatic wait_idle(input int bound, output int t_fall);
    t_fall = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (busy === 1'b0) begin
        t_fall = cyc;
        break;
      end
    end
    if (t_fall < 0) begin
      n_vec++; n_miss++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, bound);
    end
  endtask

  task automatic wait_events(input int target, input int bound);
    int ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (ev_q.size() >= target) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok == 0) begin
      n_vec++; n_miss++;
      $display("FAIL wait_events: have %0d events, required %0d", ev_q.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_vec++; if (ps2_out !== 11'h000) begin n_miss++; $display("FAIL reset_ps2_out: got %h want 000", ps2_out); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (seq_addr !== 4'd0) begin n_miss++; $display("FAIL reset_seq_addr: got %h want 0", seq_addr); end
    n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    ps2_in = {~ps2_in[10], 1'b1, 1'b0, 8'h1C};
    #1;
    n_vec++; if (ps2_out !== 11'h000) begin n_miss++; $display("FAIL pass_early: got %h want 000", ps2_out); end
    tick();
    n_vec++; if (ps2_out !== 11'h61C) begin n_miss++; $display("FAIL pass_press: got %h want 61C", ps2_out); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL pass_busy: got %b want 0", busy); end
    send_key(1'b0, 8'h1C);
    n_vec++; if (ps2_out !== 11'h01C) begin n_miss++; $display("FAIL pass_release: got %h want 01C", ps2_out); end
  endtask

  task automatic test_sequence();
    logic [9:0] exp [6];
    int base, tf;
    exp = '{10'h21C, 10'h01C, 10'h212, 10'h21B, 10'h01B, 10'h012};
    clear_rom();
    rom_mem[0] = 9'h01C; rom_mem[1] = 9'h11B;
    base = ev_q.size();
    pulse_start();
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL seq_busy: got %b want 1", busy); end
    wait_idle(300, tf);
    tick(); tick();
    n_vec++; if (ev_q.size() !== base + 6) begin n_miss++; $display("FAIL seq_count: got %0d want %0d", ev_q.size() - base, 6); end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (ev_at(base + k) !== exp[k]) begin n_miss++; $display("FAIL seq_ev%0d: got %h want %h", k, ev_at(base + k), exp[k]); end
    end
    n_vec++; if (cyc_at(base + 1) - cyc_at(base) !== 5) begin n_miss++; $display("FAIL seq_hold_span: got %0d want 5", cyc_at(base + 1) - cyc_at(base)); end
    n_vec++; if (cyc_at(base + 3) - cyc_at(base + 2) !== 1) begin n_miss++; $display("FAIL seq_shift_key_span: got %0d want 1", cyc_at(base + 3) - cyc_at(base + 2)); end
    n_vec++; if (seq_addr !== 4'd2) begin n_miss++; $display("FAIL seq_addr_end: got %h want 2", seq_addr); end
  endtask

  task automatic test_overflow();
    int base, tf;
    clear_rom();
    rom_mem[0] = 9'h015;
    base = ev_q.size();
    pulse_start();
    wait_events(base + 1, 50);
    send_key(1'b1, 8'h24);
    send_key(1'b1, 8'h2D);
    wait_idle(100, tf);
    tick(); tick();
    n_vec++; if (ev_q.size() !== base + 3) begin n_miss++; $display("FAIL ovf_count: got %0d want 3", ev_q.size() - base); end
    n_vec++; if (ev_at(base + 1) !== 10'h015) begin n_miss++; $display("FAIL ovf_release: got %h want 015", ev_at(base + 1)); end
    n_vec++; if (ev_at(base + 2) !== 10'h22D) begin n_miss++; $display("FAIL ovf_replay: got %h want 22D", ev_at(base + 2)); end
    n_vec++; if (cyc_at(base + 2) !== tf + 1) begin n_miss++; $display("FAIL ovf_replay_cycle: got %0d want %0d", cyc_at(base + 2), tf + 1); end
    n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_flag: got %b want 1", overflow); end
  endtask

  task automatic test_abort();
    logic [9:0] exp [5];
    int base, tf;
    exp = '{10'h212, 10'h21B, 10'h01B, 10'h012, 10'h276};
    clear_rom();
    rom_mem[0] = 9'h11B; rom_mem[1] = 9'h01C;
    base = ev_q.size();
    pulse_start();
    n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL abort_ovf_clear: got %b want 0", overflow); end
    wait_events(base + 2, 50);
    send_key(1'b1, 8'h76);
    wait_idle(100, tf);
    tick(); tick();
    n_vec++; if (ev_q.size() !== base + 5) begin n_miss++; $display("FAIL abort_count: got %0d want 5", ev_q.size() - base); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (ev_at(base + k) !== exp[k]) begin n_miss++; $display("FAIL abort_ev%0d: got %h want %h", k, ev_at(base + k), exp[k]); end
    end
    n_vec++; if (cyc_at(base + 4) !== tf + 1) begin n_miss++; $display("FAIL abort_replay_cycle: got %0d want %0d", cyc_at(base + 4), tf + 1); end
  endtask

  task automatic test_full_table();
    int base, tf;
    for (int i = 0; i < 16; i++) rom_mem[i] = 9'(9'h030 + i);
    base = ev_q.size();
    pulse_start();
    wait_idle(600, tf);
    tick();
    n_vec++; if (ev_q.size() !== base + 32) begin n_miss++; $display("FAIL full_count: got %0d want 32", ev_q.size() - base); end
    n_vec++; if (ev_at(base) !== 10'h230) begin n_miss++; $display("FAIL full_first: got %h want 230", ev_at(base)); end
    n_vec++; if (ev_at(base + 30) !== 10'h23F) begin n_miss++; $display("FAIL full_last_press: got %h want 23F", ev_at(base + 30)); end
    n_vec++; if (ev_at(base + 31) !== 10'h03F) begin n_miss++; $display("FAIL full_last_release: got %h want 03F", ev_at(base + 31)); end
    n_vec++; if (seq_addr !== 4'hF) begin n_miss++; $display("FAIL full_seq_addr: got %h want F", seq_addr); end
  endtask

  task automatic test_ce_freeze();
    int base, tf;
    clear_rom();
    rom_mem[0] = 9'h025;
    base = ev_q.size();
    pulse_start();
    wait_events(base + 1, 50);
    ce = 1'b0;
    repeat (20) tick();
    n_vec++; if (ev_q.size() !== base + 1) begin n_miss++; $display("FAIL ce_freeze: got %0d events want 1", ev_q.size() - base); end
    ce = 1'b1;
    wait_events(base + 2, 20);
    n_vec++; if (ev_at(base + 1) !== 10'h025) begin n_miss++; $display("FAIL ce_resume: got %h want 025", ev_at(base + 1)); end
    wait_idle(100, tf);
  endtask

  task automatic test_async_reset();
    int base, tf;
    clear_rom();
    rom_mem[0] = 9'h029;
    base = ev_q.size();
    pulse_start();
    wait_events(base + 1, 50);
    tick();
    #1;
    reset = 1'b0;
    ps2_in = 11'h000;
    #1;
    n_vec++; if (ps2_out !== 11'h000) begin n_miss++; $display("FAIL arst_ps2_out: got %h want 000", ps2_out); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_vec++; if (seq_addr !== 4'd0) begin n_miss++; $display("FAIL arst_seq_addr: got %h want 0", seq_addr); end
    tick(); tick();
    reset = 1'b1;
    tick();
    base = ev_q.size();
    pulse_start();
    wait_idle(100, tf);
    tick();
    n_vec++; if (ev_q.size() !== base + 2) begin n_miss++; $display("FAIL arst_restart_count: got %0d want 2", ev_q.size() - base); end
    n_vec++; if (ev_at(base) !== 10'h229) begin n_miss++; $display("FAIL arst_restart_press: got %h want 229", ev_at(base)); end
    n_vec++; if (ev_at(base + 1) !== 10'h029) begin n_miss++; $display("FAIL arst_restart_release: got %h want 029", ev_at(base + 1)); end
    n_vec++; if (seq_addr !== 4'd1) begin n_miss++; $display("FAIL arst_seq_addr_end: got %h want 1", seq_addr); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_passthrough();
    test_sequence();
    test_overflow();
    test_abort();
    test_full_table();
    test_ce_freeze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
